// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, D = A - B, LSB first
//
// Purpose:
//   Computes D = (A - B) mod 2^WIDTH with a single full-subtractor cell.
//   One operand bit pair is consumed per clock, LSB first, and the borrow
//   is carried between bits in a flip-flop. A complete operation occupies
//   WIDTH+2 cycles: the accept edge, WIDTH shift edges, and the edge that
//   leaves the one-cycle DONE state.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset (wins over i_start)
//   i_start    operation request, sampled only while idle
//   i_a        minuend, captured on the accepting edge
//   i_b        subtrahend, captured on the accepting edge
//   o_busy     high while operand bits are being processed
//   o_done     one-cycle completion pulse
//   o_d        registered difference, held until the next completion
//   o_bo       final borrow (1 iff A < B unsigned), held with o_d
//   o_ovf      two's-complement overflow, held with o_d
//              (present only when SUB_OVF_FLAG_EN is defined)
//
// Build option:
//   SUB_OVF_FLAG_EN  adds the o_ovf port and the operand-MSB latches

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bo
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operand shift registers, borrow flip-flop and bit counter
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  // Partial result: only the WIDTH-1 already-computed bits are stored; the
  // bit produced on the final edge goes straight into the output register.
  logic [WIDTH-2:0] r_res;

  // Output holding registers; only updated on the completion edge so
  // intermediate bits never appear on o_d.
  logic [WIDTH-1:0] r_d;
  logic             r_bo;

`ifdef SUB_OVF_FLAG_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic             w_accept;
  logic             w_last;
  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_diff_bit;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs
  assign w_bit_a       = r_ra[0];
  assign w_bit_b       = r_rb[0];
  assign w_diff_bit    = w_bit_a ^ w_bit_b ^ r_borrow;
  assign w_borrow_next = (~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_borrow);

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at bit 0
  assign w_res_next    = {w_diff_bit, r_res};

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        o_busy = 1'b1;
        if (r_count == LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Serial datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ra     <= '0;
      r_rb     <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_res    <= '0;
      r_d      <= '0;
      r_bo     <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_ra     <= i_a;
      r_rb     <= i_b;
      r_borrow <= 1'b0;
      r_count  <= '0;
`ifdef SUB_OVF_FLAG_EN
      // Sign bits are kept aside because the operand registers are shifted
      // away before the final bit is known.
      r_a_msb  <= i_a[WIDTH-1];
      r_b_msb  <= i_b[WIDTH-1];
`endif
    end else if (o_busy) begin
      r_ra     <= r_ra >> 1;
      r_rb     <= r_rb >> 1;
      r_borrow <= w_borrow_next;
      r_res    <= w_res_next[WIDTH-1:1];
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_d   <= w_res_next;
        r_bo  <= w_borrow_next;
`ifdef SUB_OVF_FLAG_EN
        // Overflow only when operand signs differ and the result sign
        // disagrees with the minuend.
        r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
`endif
      end
    end
  end

  assign o_d   = r_d;
  assign o_bo  = r_bo;
`ifdef SUB_OVF_FLAG_EN
  assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
`ifdef SUB_OVF_FLAG_EN
  logic         ovf;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;

  logic [W-1:0] last_d;
  logic         last_bo;
  logic         last_ovf;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_d     (d),
    .o_bo    (bo)
`ifdef SUB_OVF_FLAG_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  // Reference model: plain integer arithmetic
  function automatic logic [W-1:0] ref_diff(input int x, input int y);
    int r;
    r = x - y;
    if (r < 0) r = r + (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input int x, input int y);
    return (x < y);
  endfunction

  function automatic logic ref_ovf(input int x, input int y);
    int sx;
    int sy;
    int sd;
    sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
    sd = sx - sy;
    return (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; inject_at >= 0 pulses a second start that many cycles
  // into the busy phase, which must be ignored.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input int inject_at);
    int           busy_cycles;
    logic         stable;
    logic         done_in_busy;
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ovf;
    exp_d   = ref_diff(int'(op_a), int'(op_b));
    exp_bo  = ref_borrow(int'(op_a), int'(op_b));
    exp_ovf = ref_ovf(int'(op_a), int'(op_b));
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    busy_cycles  = 0;
    stable       = 1'b1;
    done_in_busy = 1'b0;
    while (busy === 1'b1 && busy_cycles < W + 4) begin
      if (!(d === last_d && bo === last_bo)) stable = 1'b0;
      if (done !== 1'b0) done_in_busy = 1'b1;
      if (busy_cycles == inject_at) begin
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
      end else begin
        start = 1'b0;
      end
      busy_cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_len", busy_cycles, W);
    check("d_stable_while_busy", stable, 1'b1);
    check("no_done_while_busy", done_in_busy, 1'b0);
    check("done_pulse", done, 1'b1);
    check("diff", d, exp_d);
    check("borrow", bo, exp_bo);
`ifdef SUB_OVF_FLAG_EN
    check("ovf", ovf, exp_ovf);
`endif
    last_d   = exp_d;
    last_bo  = exp_bo;
    last_ovf = exp_ovf;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int           pulses;
    int           cyc;
    int           last_pulse;
    int           extra_done;
    logic         stable;
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ovf;

    // Reset with start also high: reset must win
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h23;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_d", d, 8'h00);
    check("rst_bo", bo, 1'b0);
`ifdef SUB_OVF_FLAG_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    rst   = 1'b0;
    start = 1'b0;
    last_d   = '0;
    last_bo  = 1'b0;
    last_ovf = 1'b0;
    @(negedge clk);
    check("idle_after_rst", busy, 1'b0);

    // Directed examples
    run_op(8'h5A, 8'h23, -1);
    check("ex_5a_23", d, 8'h37);
    run_op(8'h00, 8'h01, -1);
    check("ex_00_01", {bo, d}, 9'h1FF);
    run_op(8'hFF, 8'hFF, -1);
    check("ex_ff_ff", {bo, d}, 9'h000);
`ifdef SUB_OVF_FLAG_EN
    run_op(8'h80, 8'h01, -1);
    check("ex_80_01", {ovf, bo, d}, 10'h27F);
    run_op(8'h7F, 8'hFF, -1);
    check("ex_7f_ff", {ovf, bo, d}, 10'h380);
`endif

    // Start while busy is ignored and not queued
    run_op(8'h33, 8'h11, 3);
    extra_done = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    check("ignored_start", extra_done, 0);
    check("ignored_start_d", d, 8'h22);

    // Randomised operations
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), -1);
    end

    // Reset on the 4th shift edge abandons the operation
    a = 8'hC3;
    b = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy_cleared", busy, 1'b0);
    check("abort_no_done", done, 1'b0);
    check("abort_d", d, 8'h00);
    check("abort_bo", bo, 1'b0);
    rst = 1'b0;
    last_d   = '0;
    last_bo  = 1'b0;
    last_ovf = 1'b0;
    run_op(8'h05, 8'h03, -1);
    check("after_abort", {bo, d}, 9'h002);

    // Start held continuously: one completion every W+2 cycles
    a = W'($urandom);
    b = W'($urandom);
    exp_d   = ref_diff(int'(a), int'(b));
    exp_bo  = ref_borrow(int'(a), int'(b));
    exp_ovf = ref_ovf(int'(a), int'(b));
    start = 1'b1;
    pulses = 0;
    cyc = 0;
    last_pulse = 0;
    stable = 1'b1;
    while (pulses < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        check("held_diff", d, exp_d);
        check("held_borrow", bo, exp_bo);
`ifdef SUB_OVF_FLAG_EN
        check("held_ovf", ovf, exp_ovf);
`endif
        if (pulses > 0) check("held_period", cyc - last_pulse, W + 2);
        last_pulse = cyc;
        pulses++;
        last_d   = exp_d;
        last_bo  = exp_bo;
        last_ovf = exp_ovf;
        if (pulses < 4) begin
          a = W'($urandom);
          b = W'($urandom);
          exp_d   = ref_diff(int'(a), int'(b));
          exp_bo  = ref_borrow(int'(a), int'(b));
          exp_ovf = ref_ovf(int'(a), int'(b));
        end else begin
          start = 1'b0;
        end
      end else if (!(d === last_d && bo === last_bo)) begin
        stable = 1'b0;
      end
    end
    start = 1'b0;
    check("held_pulse_count", pulses, 4);
    check("held_d_stable", stable, 1'b1);
    repeat (2) @(negedge clk);
    check("held_final_idle", {busy, done}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
